bht_update_gen: RTL and testbench

- Producer side of the branch-history-table update interface.
- Buffers resolved conditional-branch outcomes from the branch unit as speculative entries and promotes them in order as commit confirms them.
- Emits committed outcomes as ariane_pkg::bht_update_t, at most one per cycle, to the frontend BHT's update port.
- Speculative outcomes squashed by a pipeline flush never reach the BHT.

---
 rtl/bht_update_gen.sv | 130 +++++++++++++
 tb/tb_bht_update_gen.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bht_update_gen.sv
// Purpose: buffers resolved branch outcomes as speculative entries, promotes them on commit and drains them to the BHT.
// Latency: commit_i in cycle N gives bht_update_o valid in cycle N+2; one update per cycle at most.
// Backpressure: resolve_ready_o drops when the buffer is full. A resolution offered while full is dropped. The BHT never stalls us.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   flush_i             squash all speculative (uncommitted) entries
//   debug_mode_i        block new allocations; commit and drain continue
//   resolve_valid_i     a conditional branch resolved this cycle
//   resolve_pc_i        PC of that branch
//   resolve_taken_i     direction of that branch
//   resolve_ready_o     buffer not full; depends on state only
//   commit_i            the oldest speculative entry has committed
//   bht_update_o        registered {valid, pc[VLEN-1:0], taken}; same bit layout as ariane_pkg::bht_update_t
//   spec_cnt_o          registered count of speculative entries
module bht_update_gen #(
    parameter int DEPTH = 4,
    parameter int VLEN  = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   debug_mode_i,
    input  logic                   resolve_valid_i,
    input  logic [VLEN-1:0]        resolve_pc_i,
    input  logic                   resolve_taken_i,
    output logic                   resolve_ready_o,
    input  logic                   commit_i,
    output logic [VLEN+1:0]        bht_update_o,
    output logic [$clog2(DEPTH):0] spec_cnt_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

    // Each pointer carries a wrap bit above the index. Full means the indices
    // match and the wrap bits differ. Empty means all bits match.
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] cm_ptr_q, cm_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] spec_cnt_q, spec_cnt_d;

    logic            upd_vld_q, upd_vld_d;
    logic [VLEN-1:0] upd_pc_q, upd_pc_d;
    logic            upd_taken_q, upd_taken_d;

    logic [VLEN-1:0] ent_pc_q    [DEPTH];
    logic            ent_taken_q [DEPTH];

    logic [PW-1:0] used_cnt;
    logic [PW-1:0] spec_now;
    logic [PW-1:0] comm_now;
    logic          full;
    logic          alloc;
    logic          do_commit;
    logic          do_drain;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    always_comb begin
        used_cnt  = wr_ptr_q - rd_ptr_q;
        spec_now  = wr_ptr_q - cm_ptr_q;
        comm_now  = cm_ptr_q - rd_ptr_q;
        full      = (used_cnt == FULL_CNT);
        wr_idx    = wr_ptr_q[IW-1:0];
        rd_idx    = rd_ptr_q[IW-1:0];
        // A flush also kills a same-cycle resolution.
        alloc     = resolve_valid_i && !full && !debug_mode_i && !flush_i;
        // Uses the count at the start of the cycle, so an entry allocated in
        // this cycle cannot be committed in this cycle.
        do_commit = commit_i && (spec_now != '0);
        do_drain  = (comm_now != '0);
    end

    assign resolve_ready_o = !full;

    always_comb begin
        cm_ptr_d = cm_ptr_q + PW'(do_commit);
        // The flush takes effect after the commit, so the committing entry survives.
        if (flush_i) begin
            wr_ptr_d = cm_ptr_d;
        end else begin
            wr_ptr_d = wr_ptr_q + PW'(alloc);
        end
        rd_ptr_d   = rd_ptr_q + PW'(do_drain);
        spec_cnt_d = wr_ptr_d - cm_ptr_d;

        // When idle, only valid drops. The pc and taken fields keep their last value.
        upd_vld_d   = do_drain;
        upd_pc_d    = upd_pc_q;
        upd_taken_d = upd_taken_q;
        if (do_drain) begin
            upd_pc_d    = ent_pc_q[rd_idx];
            upd_taken_d = ent_taken_q[rd_idx];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q    <= '0;
            cm_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            spec_cnt_q  <= '0;
            upd_vld_q   <= 1'b0;
            upd_pc_q    <= '0;
            upd_taken_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            cm_ptr_q    <= cm_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            spec_cnt_q  <= spec_cnt_d;
            upd_vld_q   <= upd_vld_d;
            upd_pc_q    <= upd_pc_d;
            upd_taken_q <= upd_taken_d;
        end
    end

    // The payload storage has no reset. An entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (alloc) begin
            ent_pc_q[wr_idx]    <= resolve_pc_i;
            ent_taken_q[wr_idx] <= resolve_taken_i;
        end
    end

    assign bht_update_o = {upd_vld_q, upd_pc_q, upd_taken_q};
    assign spec_cnt_o   = spec_cnt_q;

endmodule

// File: tb/tb_bht_update_gen.sv
module tb_bht_update_gen;

    localparam int DEPTH = 4;
    localparam int VLEN  = 64;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            flush_i = 1'b0;
    logic            debug_mode_i = 1'b0;
    logic            resolve_valid_i = 1'b0;
    logic [VLEN-1:0] resolve_pc_i = '0;
    logic            resolve_taken_i = 1'b0;
    logic            resolve_ready_o;
    logic            commit_i = 1'b0;
    logic [VLEN+1:0] bht_update_o;
    logic [CW-1:0]   spec_cnt_o;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [VLEN-1:0] pc;
        logic            tk;
    } ent_t;

    // Reference model: the branches in program order, split into speculative
    // and committed lists, plus the updates the BHT should see next.
    ent_t spec_m[$];
    ent_t comm_m[$];
    ent_t exp_q[$];
    logic [VLEN-1:0] last_pc = '0;
    logic            last_tk = 1'b0;

    bht_update_gen #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .debug_mode_i    (debug_mode_i),
        .resolve_valid_i (resolve_valid_i),
        .resolve_pc_i    (resolve_pc_i),
        .resolve_taken_i (resolve_taken_i),
        .resolve_ready_o (resolve_ready_o),
        .commit_i        (commit_i),
        .bht_update_o    (bht_update_o),
        .spec_cnt_o      (spec_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model update at every clock edge, using the state before the edge.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spec_m.delete();
            comm_m.delete();
            exp_q.delete();
            last_pc = '0;
            last_tk = 1'b0;
        end else begin
            int  ns;
            int  nc;
            bit  rdy;
            ns  = spec_m.size();
            nc  = comm_m.size();
            rdy = (ns + nc) != DEPTH;
            if (nc > 0) exp_q.push_back(comm_m.pop_front());
            if (commit_i && ns > 0) comm_m.push_back(spec_m.pop_front());
            if (flush_i) spec_m.delete();
            else if (resolve_valid_i && rdy && !debug_mode_i)
                spec_m.push_back('{pc: resolve_pc_i, tk: resolve_taken_i});
        end
    end

    // Monitor: samples the outputs on the falling edge.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            chk("ready", 64'(resolve_ready_o), 64'((spec_m.size() + comm_m.size()) != DEPTH));
            chk("spec_cnt", 64'(spec_cnt_o), 64'(spec_m.size()));
            if (exp_q.size() > 0) begin
                ent_t e;
                e = exp_q.pop_front();
                chk("upd_valid", 64'(bht_update_o[VLEN+1]), 64'd1);
                chk("upd_pc", bht_update_o[VLEN:1], e.pc);
                chk("upd_taken", 64'(bht_update_o[0]), 64'(e.tk));
                last_pc = e.pc;
                last_tk = e.tk;
            end else begin
                chk("idle_valid", 64'(bht_update_o[VLEN+1]), 64'd0);
                chk("idle_pc_hold", bht_update_o[VLEN:1], last_pc);
                chk("idle_tk_hold", 64'(bht_update_o[0]), 64'(last_tk));
            end
        end
    end

    task automatic step(input bit rv, input logic [VLEN-1:0] pc, input bit tk,
                        input bit cm, input bit fl, input bit dbg);
        resolve_valid_i = rv;
        resolve_pc_i    = pc;
        resolve_taken_i = tk;
        commit_i        = cm;
        flush_i         = fl;
        debug_mode_i    = dbg;
        @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk_i);
        chk("rst_valid", 64'(bht_update_o[VLEN+1]), 64'd0);
        chk("rst_spec_cnt", 64'(spec_cnt_o), 64'd0);
        chk("rst_ready", 64'(resolve_ready_o), 64'd1);
        rst_ni = 1'b1;

        // First commit-to-update latency
        step(1, 64'h8000_0010, 1, 0, 0, 0);
        step(0, '0, 0, 1, 0, 0);
        idle(4);

        // Fill the buffer; a fifth resolve is dropped, then drain in order
        for (int i = 0; i < 4; i++) step(1, 64'h100 + 64'(4 * i), (i % 2) == 0, 0, 0, 0);
        chk("full_ready", 64'(resolve_ready_o), 64'd0);
        step(1, 64'h110, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, '0, 0, 1, 0, 0);
        idle(4);

        // Same-cycle commit and flush
        step(1, 64'h200, 1, 0, 0, 0);
        step(1, 64'h204, 0, 0, 0, 0);
        step(0, '0, 0, 1, 1, 0);
        chk("flush_spec_cnt", 64'(spec_cnt_o), 64'd0);
        step(1, 64'h300, 1, 0, 0, 0);
        step(0, '0, 0, 1, 0, 0);
        idle(4);

        // Debug mode blocks allocation
        step(1, 64'h400, 0, 1, 0, 1);
        chk("dbg_spec_cnt", 64'(spec_cnt_o), 64'd0);
        idle(4);

        // Streaming with pointer wrap
        for (int i = 0; i < 12; i++) step(1, 64'h1000 + 64'(4 * i), i[0], i > 0, 0, 0);
        step(0, '0, 0, 1, 0, 0);
        idle(4);

        // Reset in the middle of traffic
        step(1, 64'h500, 1, 0, 0, 0);
        step(1, 64'h504, 0, 1, 0, 0);
        step(1, 64'h508, 1, 1, 0, 0);
        step(0, '0, 0, 0, 0, 0);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_valid", 64'(bht_update_o[VLEN+1]), 64'd0);
        chk("async_rst_spec", 64'(spec_cnt_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle(6);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 3) != 0, {$urandom, $urandom}, 1'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 29) == 0);
        end
        for (int i = 0; i < DEPTH + 2; i++) step(0, '0, 0, 1, 0, 0);
        idle(4);
        chk("end_exp_empty", 64'(exp_q.size()), 64'd0);
        chk("end_spec_cnt", 64'(spec_cnt_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
